// File: rtl/clkdiv_prog.sv
// Programmable multi-channel clock divider with 50% duty outputs.
// New divisor/enable settings are staged and applied only on a falling clkout toggle or while idle.
module clkdiv_prog #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 2,
   localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CW-1:0]       cfg_chan,
   input  logic [WIDTH-1:0]    cfg_div,
   input  logic                cfg_en,
   output logic [CHANNELS-1:0] clkout,
   output logic [CHANNELS-1:0] tick
);

   logic [CHANNELS-1:0] pvalid_vec;
   logic                cfg_fire;

   // Only one update may be outstanding across all channels.
   assign cfg_ready = ~|pvalid_vec;
   assign cfg_fire  = cfg_valid && cfg_ready;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [WIDTH-1:0] div_q, div_d;
         logic [WIDTH-1:0] cnt_q, cnt_d;
         logic [WIDTH-1:0] pdiv_q, pdiv_d;
         logic             en_q, en_d;
         logic             pen_q, pen_d;
         logic             pvalid_q, pvalid_d;
         logic             clkout_q, clkout_d;
         logic             tick_q, tick_d;
         logic             running;
         logic             wrap;
         logic             hit;

         assign running = en_q && (div_q != '0);
         assign wrap    = running && (cnt_q == (div_q - WIDTH'(1)));
         // Out-of-range channel indices match no channel and are dropped.
         assign hit     = cfg_fire && (cfg_chan == CW'(gi));

         always_comb begin
            div_d    = div_q;
            en_d     = en_q;
            cnt_d    = cnt_q;
            pdiv_d   = pdiv_q;
            pen_d    = pen_q;
            pvalid_d = pvalid_q;
            clkout_d = clkout_q;
            tick_d   = 1'b0;

            if (running) begin
               if (wrap) begin
                  cnt_d    = '0;
                  clkout_d = ~clkout_q;
                  tick_d   = ~clkout_q;
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end else begin
               cnt_d    = '0;
               clkout_d = 1'b0;
            end

            // Apply only at a high-to-low toggle so no phase is ever truncated.
            if (pvalid_q && (!running || (wrap && clkout_q))) begin
               div_d    = pdiv_q;
               en_d     = pen_q;
               cnt_d    = '0;
               pvalid_d = 1'b0;
            end

            if (hit) begin
               pdiv_d   = cfg_div;
               pen_d    = cfg_en;
               pvalid_d = 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               div_q    <= '0;
               en_q     <= 1'b0;
               cnt_q    <= '0;
               pdiv_q   <= '0;
               pen_q    <= 1'b0;
               pvalid_q <= 1'b0;
               clkout_q <= 1'b0;
               tick_q   <= 1'b0;
            end else begin
               div_q    <= div_d;
               en_q     <= en_d;
               cnt_q    <= cnt_d;
               pdiv_q   <= pdiv_d;
               pen_q    <= pen_d;
               pvalid_q <= pvalid_d;
               clkout_q <= clkout_d;
               tick_q   <= tick_d;
            end
         end

         assign pvalid_vec[gi] = pvalid_q;
         assign clkout[gi]     = clkout_q;
         assign tick[gi]       = tick_q;
      end
   endgenerate

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed scoreboard bench for clkdiv_prog (WIDTH=8, CHANNELS=2) plus a
// single-channel instance used to exercise an out-of-range channel index.
module tb_clkdiv_prog;
   localparam int WIDTH    = 8;
   localparam int CHANNELS = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             cfg_valid;
   logic             cfg_valid_oor;
   logic             cfg_chan;
   logic [WIDTH-1:0] cfg_div;
   logic             cfg_en;
   logic             cfg_ready;
   logic             cfg_ready_oor;
   logic [1:0]       clkout;
   logic [1:0]       tick;
   logic [0:0]       clkout_oor;
   logic [0:0]       tick_oor;

   typedef struct {
      string      tag;
      logic [1:0] c;
      logic [1:0] t;
      logic       r;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   clkdiv_prog #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .cfg_en    (cfg_en),
      .clkout    (clkout),
      .tick      (tick)
   );

   // One channel only: cfg_chan=1 is out of range here.
   clkdiv_prog #(.WIDTH(WIDTH), .CHANNELS(1)) u_oor (
      .clk       (clk),
      .reset     (reset),
      .cfg_valid (cfg_valid_oor),
      .cfg_ready (cfg_ready_oor),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .cfg_en    (cfg_en),
      .clkout    (clkout_oor),
      .tick      (tick_oor)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [1:0] c, input logic [1:0] t, input logic r);
      exp_t e;
      e.tag = tag;
      e.c   = c;
      e.t   = t;
      e.r   = r;
      sb_q.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      n_checks++;
      assert (sb_q.size() != 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=0 entries required=1 entry");
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         $display("%s: clkout=%b tick=%b cfg_ready=%b oor_clkout=%b oor_ready=%b",
                  e.tag, clkout, tick, cfg_ready, clkout_oor, cfg_ready_oor);
         n_checks++;
         assert (clkout === e.c) else begin
            n_fail++;
            $error("FAIL %s clkout observed=%b expected=%b", e.tag, clkout, e.c);
         end
         n_checks++;
         assert (tick === e.t) else begin
            n_fail++;
            $error("FAIL %s tick observed=%b expected=%b", e.tag, tick, e.t);
         end
         n_checks++;
         assert (cfg_ready === e.r) else begin
            n_fail++;
            $error("FAIL %s cfg_ready observed=%b expected=%b", e.tag, cfg_ready, e.r);
         end
         n_checks++;
         assert ((clkout_oor === 1'b0) && (tick_oor === 1'b0) && (cfg_ready_oor === 1'b1)) else begin
            n_fail++;
            $error("FAIL %s oor_outputs observed=%b%b%b expected=001",
                   e.tag, clkout_oor, tick_oor, cfg_ready_oor);
         end
      end
   endtask

   task automatic drain(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic oor, input logic chan, input logic [WIDTH-1:0] div, input logic en);
      cfg_chan      = chan;
      cfg_div       = div;
      cfg_en        = en;
      cfg_valid     = ~oor;
      cfg_valid_oor = oor;
      step();
      cfg_valid     = 1'b0;
      cfg_valid_oor = 1'b0;
   endtask

   initial begin
      logic c0, t0, c1, t1, r;
      reset         = 1'b1;
      cfg_valid     = 1'b0;
      cfg_valid_oor = 1'b0;
      cfg_chan      = 1'b0;
      cfg_div       = '0;
      cfg_en        = 1'b0;

      // Reset for two cycles with a request presented that must be ignored.
      push("A_rst0", 2'b00, 2'b00, 1'b1);
      push("A_rst1", 2'b00, 2'b00, 1'b1);
      @(posedge clk);
      #1;
      cfg_valid = 1'b1;
      cfg_div   = 8'd3;
      cfg_en    = 1'b1;
      drain(2);
      reset     = 1'b0;
      cfg_valid = 1'b0;
      for (int k = 0; k < 6; k++) push($sformatf("A_post%0d", k), 2'b00, 2'b00, 1'b1);
      drain(6);

      // ch0 D=3 from idle: rises 4 edges after acceptance, 3 high / 3 low.
      for (int k = 0; k <= 16; k++) begin
         c0 = (k >= 4) && (((k - 4) % 6) < 3);
         t0 = (k >= 4) && (((k - 4) % 6) == 0);
         push($sformatf("B%0d", k), {1'b0, c0}, {1'b0, t0}, k != 0);
      end
      send(1'b0, 1'b0, 8'd3, 1'b1);
      drain(16);

      // D=1 accepted in first high cycle: high still lasts 3, then period 2.
      for (int j = 0; j <= 9; j++) begin
         if (j < 2) begin
            c0 = 1'b1; t0 = 1'b0; r = 1'b0;
         end else if (j == 2) begin
            c0 = 1'b0; t0 = 1'b0; r = 1'b1;
         end else begin
            c0 = (j % 2) == 1; t0 = (j % 2) == 1; r = 1'b1;
         end
         push($sformatf("C%0d", j), {1'b0, c0}, {1'b0, t0}, r);
      end
      send(1'b0, 1'b0, 8'd1, 1'b1);
      drain(9);

      // Stop ch0 (en=0) while toggling at period 2.
      push("C2_0", 2'b00, 2'b00, 1'b0);
      push("C2_1", 2'b01, 2'b01, 1'b0);
      for (int m = 2; m <= 7; m++) push($sformatf("C2_%0d", m), 2'b00, 2'b00, 1'b1);
      send(1'b0, 1'b0, 8'd5, 1'b0);
      drain(7);

      // ch1 D=4, then en=0 accepted mid-high.
      for (int s = 0; s <= 19; s++) begin
         c1 = (s >= 5) && (s <= 8);
         t1 = (s == 5);
         r  = !((s == 0) || (s == 7) || (s == 8));
         push($sformatf("D%0d", s), {c1, 1'b0}, {t1, 1'b0}, r);
      end
      send(1'b0, 1'b1, 8'd4, 1'b1);
      drain(6);
      send(1'b0, 1'b1, 8'd4, 1'b0);
      drain(12);

      // Out-of-range channel on the one-channel instance.
      for (int s = 0; s < 8; s++) push($sformatf("E_oor%0d", s), 2'b00, 2'b00, 1'b1);
      send(1'b1, 1'b1, 8'd3, 1'b1);
      drain(7);

      // D=0 en=1 on idle ch0: no output activity.
      push("E_d0_0", 2'b00, 2'b00, 1'b0);
      for (int s = 1; s < 8; s++) push($sformatf("E_d0_%0d", s), 2'b00, 2'b00, 1'b1);
      send(1'b0, 1'b0, 8'd0, 1'b1);
      drain(7);

      // Both channels running, ch0 update pending, then a one-cycle reset.
      for (int k = 0; k <= 8; k++) begin
         c0 = (k >= 3) && (((k - 3) % 4) < 2);
         t0 = (k >= 3) && (((k - 3) % 4) == 0);
         c1 = (k >= 6) && (((k - 6) % 6) < 3);
         t1 = (k >= 6) && (((k - 6) % 6) == 0);
         r  = !((k == 0) || (k == 2) || (k == 8));
         push($sformatf("F%0d", k), {c1, c0}, {t1, t0}, r);
      end
      send(1'b0, 1'b0, 8'd2, 1'b1);
      drain(1);
      send(1'b0, 1'b1, 8'd3, 1'b1);
      drain(5);
      send(1'b0, 1'b0, 8'd1, 1'b1);
      reset = 1'b1;
      push("F_rst", 2'b00, 2'b00, 1'b1);
      step();
      reset = 1'b0;
      for (int k = 0; k < 8; k++) push($sformatf("F_post%0d", k), 2'b00, 2'b00, 1'b1);
      drain(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
